// File: rtl/fb_mem_stage_if.sv
// Firebird data-bus interface: request/grant issue channel plus load-data return.
// The master modport is the MEM stage; the slave modport is the memory side.
interface fb_mem_stage_if #(
    parameter int DW = 32
);
    logic          dbus_req;
    logic          dbus_we;
    logic [DW-1:0] dbus_addr;
    logic [DW-1:0] dbus_wdata;
    logic          dbus_gnt;
    logic          dbus_rvalid;
    logic [DW-1:0] dbus_rdata;

    modport master (
        output dbus_req,
        output dbus_we,
        output dbus_addr,
        output dbus_wdata,
        input  dbus_gnt,
        input  dbus_rvalid,
        input  dbus_rdata
    );

    modport slave (
        input  dbus_req,
        input  dbus_we,
        input  dbus_addr,
        input  dbus_wdata,
        output dbus_gnt,
        output dbus_rvalid,
        output dbus_rdata
    );
endinterface

// File: rtl/fb_mem_stage.sv
// Firebird MEM stage: data-bus load/store sequencer and MEM/WB pipeline register.
// Optional bus watchdog enabled by defining FB_MEM_TIMEOUT_EN.
module fb_mem_stage #(
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_mem_read,
    input  logic                mem_mem_write,
    input  logic                mem_mem_to_reg,
    input  logic                mem_reg_write,
    input  logic [DW-1:0]       mem_alu_res,
    input  logic [DW-1:0]       mem_rs2_data,
    input  logic [4:0]          mem_register_rd,
    fb_mem_stage_if.master      dbus,
    output logic                mem_stall,
    output logic                mem_bus_err,
    output logic                wb_mem_to_reg,
    output logic                wb_reg_write,
    output logic [DW-1:0]       wb_alu_res,
    output logic [DW-1:0]       wb_mem_rdata,
    output logic [4:0]          wb_register_rd
);

    generate
        if ((TIMEOUT_CYCLES >> TO_W) != 0) begin : g_to_w_too_small
            $error("fb_mem_stage: TO_W too narrow for TIMEOUT_CYCLES");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic          req_q;
    logic          we_q;
    logic [DW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          access;
    logic          done_now;
    logic          aborted;

    assign access = mem_mem_read | mem_mem_write;

    assign mem_stall = ((state == IDLE) && access) || (state == REQ) || (state == WAIT);

    assign dbus.dbus_req   = req_q;
    assign dbus.dbus_we    = we_q;
    assign dbus.dbus_addr  = addr_q;
    assign dbus.dbus_wdata = wdata_q;

    // A store completes on grant; a load completes when its data returns.
    always_comb begin
        done_now = 1'b0;
        case (state)
            REQ:     done_now = dbus.dbus_gnt && (we_q || dbus.dbus_rvalid);
            WAIT:    done_now = dbus.dbus_rvalid;
            default: done_now = 1'b0;
        endcase
    end

`ifdef FB_MEM_TIMEOUT_EN
    localparam logic [DW-1:0] ABORT_DATA = DW'(32'hDEADBEEF);

    logic [TO_W-1:0] to_cnt;
    logic            abort_q;
    logic            to_hit;

    // Fires on the TIMEOUT_CYCLES-th outstanding cycle; a completion in that cycle wins.
    assign to_hit = ((state == REQ) || (state == WAIT)) && !done_now &&
                    (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= '0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= to_hit;
            if (state == IDLE) begin
                to_cnt <= '0;
            end else if ((state == REQ) || (state == WAIT)) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign aborted = abort_q;
`else
    assign aborted = 1'b0;
`endif

    assign mem_bus_err = aborted;

    // Bus sequencer: latches the access and walks IDLE -> REQ -> [WAIT] -> DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        addr_q  <= mem_alu_res;
                        wdata_q <= mem_rs2_data;
                        we_q    <= mem_mem_write & ~mem_mem_read;
                        req_q   <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (done_now) begin
                        req_q <= 1'b0;
                        state <= DONE;
                        if (!we_q) begin
                            rdata_q <= dbus.dbus_rdata;
                        end
                    end
`ifdef FB_MEM_TIMEOUT_EN
                    else if (to_hit) begin
                        req_q <= 1'b0;
                        state <= DONE;
                    end
`endif
                    else if (dbus.dbus_gnt) begin
                        req_q <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (done_now) begin
                        rdata_q <= dbus.dbus_rdata;
                        state   <= DONE;
                    end
`ifdef FB_MEM_TIMEOUT_EN
                    else if (to_hit) begin
                        state <= DONE;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, result on DONE, pass-through otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_mem_to_reg  <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_alu_res     <= '0;
            wb_mem_rdata   <= '0;
            wb_register_rd <= '0;
        end else if (mem_stall) begin
            wb_mem_to_reg <= 1'b0;
            wb_reg_write  <= 1'b0;
        end else if (state == DONE) begin
            wb_mem_to_reg  <= mem_mem_to_reg;
            wb_reg_write   <= mem_reg_write & ~aborted;
            wb_alu_res     <= mem_alu_res;
            wb_register_rd <= mem_register_rd;
`ifdef FB_MEM_TIMEOUT_EN
            if (aborted) begin
                wb_mem_rdata <= ABORT_DATA;
            end else begin
                wb_mem_rdata <= we_q ? '0 : rdata_q;
            end
`else
            wb_mem_rdata <= we_q ? '0 : rdata_q;
`endif
        end else begin
            wb_mem_to_reg  <= mem_mem_to_reg;
            wb_reg_write   <= mem_reg_write;
            wb_alu_res     <= mem_alu_res;
            wb_register_rd <= mem_register_rd;
            wb_mem_rdata   <= '0;
        end
    end

endmodule

// File: tb/tb_fb_mem_stage.sv
// Directed bench for fb_mem_stage: vector table of pipeline/bus transactions plus
// reset-in-flight and (with FB_MEM_TIMEOUT_EN) watchdog sequences.
module tb_fb_mem_stage;

`ifdef FB_MEM_TIMEOUT_EN
    localparam int TO_CYC = 4;
`else
    localparam int TO_CYC = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
    logic [31:0] mem_alu_res, mem_rs2_data;
    logic [4:0]  mem_register_rd;
    logic        mem_stall, mem_bus_err;
    logic        wb_mem_to_reg, wb_reg_write;
    logic [31:0] wb_alu_res, wb_mem_rdata;
    logic [4:0]  wb_register_rd;

    int n_checks = 0;
    int n_fail   = 0;

    fb_mem_stage_if #(.DW(32)) dbus_if ();

    fb_mem_stage #(
        .DW(32),
        .TIMEOUT_CYCLES(TO_CYC),
        .TO_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write),
        .mem_mem_to_reg(mem_mem_to_reg),
        .mem_reg_write(mem_reg_write),
        .mem_alu_res(mem_alu_res),
        .mem_rs2_data(mem_rs2_data),
        .mem_register_rd(mem_register_rd),
        .dbus(dbus_if),
        .mem_stall(mem_stall),
        .mem_bus_err(mem_bus_err),
        .wb_mem_to_reg(wb_mem_to_reg),
        .wb_reg_write(wb_reg_write),
        .wb_alu_res(wb_alu_res),
        .wb_mem_rdata(wb_mem_rdata),
        .wb_register_rd(wb_register_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd_en, wr_en, to_reg, reg_wr;
        logic [31:0] alu, rs2;
        logic [4:0]  rd;
        int          gnt_dly;      // REQ cycles before gnt
        int          rv_dly;       // cycles from gnt to rvalid (0 = same cycle)
        logic [31:0] rdata;
        logic        exp_we;
        int          exp_stall;    // cycles with mem_stall = 1
        int          exp_req;      // cycles with dbus_req = 1
        logic        exp_wb_rw, exp_wb_tr;
        logic [31:0] exp_wb_rdata;
        int          exp_err;      // mem_bus_err pulse cycles
    } vec_t;

    vec_t tbl [0:6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_nop();
        mem_mem_read    = 1'b0;
        mem_mem_write   = 1'b0;
        mem_mem_to_reg  = 1'b0;
        mem_reg_write   = 1'b0;
        mem_alu_res     = 32'h0;
        mem_rs2_data    = 32'h0;
        mem_register_rd = 5'd0;
        dbus_if.dbus_gnt    = 1'b0;
        dbus_if.dbus_rvalid = 1'b0;
        dbus_if.dbus_rdata  = 32'h0;
    endtask

    // Called between a negedge and the following posedge.
    task automatic run_vec(input vec_t v, input string tag);
        int  stall_cnt = 0, req_cnt = 0, since = 0, err_cnt = 0;
        int  stab_bad = 0, bubble_bad = 0;
        bit  granted = 0, prev_stall = 0, done = 0;
        mem_mem_read    = v.rd_en;
        mem_mem_write   = v.wr_en;
        mem_mem_to_reg  = v.to_reg;
        mem_reg_write   = v.reg_wr;
        mem_alu_res     = v.alu;
        mem_rs2_data    = v.rs2;
        mem_register_rd = v.rd;
        for (int c = 0; c < 64 && !done; c++) begin
            if (prev_stall && (wb_reg_write || wb_mem_to_reg)) bubble_bad++;
            dbus_if.dbus_gnt    = 1'b0;
            dbus_if.dbus_rvalid = 1'b0;
            dbus_if.dbus_rdata  = 32'h0;
            if (dbus_if.dbus_req) begin
                if (dbus_if.dbus_addr !== v.alu || dbus_if.dbus_wdata !== v.rs2 ||
                    dbus_if.dbus_we !== v.exp_we) stab_bad++;
                if (req_cnt == v.gnt_dly) begin
                    dbus_if.dbus_gnt = 1'b1;
                    granted = 1;
                    if (v.rv_dly == 0 && !v.exp_we) begin
                        dbus_if.dbus_rvalid = 1'b1;
                        dbus_if.dbus_rdata  = v.rdata;
                    end
                end
                req_cnt++;
            end else if (granted && !v.exp_we) begin
                since++;
                if (since == v.rv_dly) begin
                    dbus_if.dbus_rvalid = 1'b1;
                    dbus_if.dbus_rdata  = v.rdata;
                end
            end
            #1;
            if (mem_bus_err) err_cnt++;
            if (mem_stall) begin
                stall_cnt++;
                prev_stall = 1;
                @(negedge clk);
            end else begin
                done = 1;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: actual no completion required completion within 64 cycles", tag);
        end
        @(posedge clk);
        #1;
        set_nop();
        check({tag, "_stall"},   stall_cnt,      v.exp_stall);
        check({tag, "_req"},     req_cnt,        v.exp_req);
        check({tag, "_stable"},  stab_bad,       0);
        check({tag, "_bubble"},  bubble_bad,     0);
        check({tag, "_err"},     err_cnt,        v.exp_err);
        check({tag, "_errpost"}, mem_bus_err,    0);
        check({tag, "_wb_rw"},   wb_reg_write,   v.exp_wb_rw);
        check({tag, "_wb_tr"},   wb_mem_to_reg,  v.exp_wb_tr);
        check({tag, "_wb_alu"},  wb_alu_res,     v.alu);
        check({tag, "_wb_rd"},   wb_register_rd, v.rd);
        check({tag, "_wb_data"}, wb_mem_rdata,   v.exp_wb_rdata);
        @(negedge clk);
    endtask

    initial begin
        // rd,wr,tr,rw, alu, rs2, rd, gnt, rv, rdata, we, stall, req, wb_rw, wb_tr, wb_rdata, err
        tbl[0] = '{1'b0,1'b0,1'b0,1'b1, 32'h10, 32'h0, 5'd5, 0,0, 32'h0,
                   1'b0, 0,0, 1'b1,1'b0, 32'h0, 0};
        tbl[1] = '{1'b0,1'b0,1'b1,1'b1, 32'hFFFFFFFF, 32'h77, 5'd31, 0,0, 32'h0,
                   1'b0, 0,0, 1'b1,1'b1, 32'h0, 0};
        tbl[2] = '{1'b0,1'b1,1'b0,1'b0, 32'h100, 32'hCAFEBABE, 5'd0, 1,0, 32'h0,
                   1'b1, 3,2, 1'b0,1'b0, 32'h0, 0};
        tbl[3] = '{1'b1,1'b0,1'b1,1'b1, 32'h200, 32'h0, 5'd9, 0,3, 32'h12345678,
                   1'b0, 5,1, 1'b1,1'b1, 32'h12345678, 0};
        tbl[4] = '{1'b1,1'b0,1'b1,1'b1, 32'h204, 32'h0, 5'd10, 0,0, 32'hA5A5A5A5,
                   1'b0, 2,1, 1'b1,1'b1, 32'hA5A5A5A5, 0};
        tbl[5] = '{1'b1,1'b1,1'b1,1'b1, 32'h208, 32'h55555555, 5'd11, 2,1, 32'h0BADF00D,
                   1'b0, 5,3, 1'b1,1'b1, 32'h0BADF00D, 0};
        tbl[6] = '{1'b0,1'b1,1'b0,1'b0, 32'h10C, 32'h01234567, 5'd2, 0,0, 32'h0,
                   1'b1, 2,1, 1'b0,1'b0, 32'h0, 0};

        rst = 1'b1;
        set_nop();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_req",   dbus_if.dbus_req, 0);
        check("rst_stall", mem_stall,        0);
        check("rst_wb",    {wb_reg_write, wb_mem_to_reg, wb_register_rd, mem_bus_err}, 0);
        check("rst_data",  wb_alu_res | wb_mem_rdata | dbus_if.dbus_addr, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i], $sformatf("v%0d", i));
        end

        // Reset while a load sits in WAIT, then a stray rvalid in IDLE.
        mem_mem_read    = 1'b1;
        mem_mem_to_reg  = 1'b1;
        mem_reg_write   = 1'b1;
        mem_alu_res     = 32'h400;
        mem_register_rd = 5'd3;
        @(negedge clk);
        dbus_if.dbus_gnt = 1'b1;
        @(negedge clk);
        dbus_if.dbus_gnt = 1'b0;
        @(negedge clk);
        #1;
        check("wait_stall", mem_stall,        1);
        check("wait_req",   dbus_if.dbus_req, 0);
        rst = 1'b1;
        set_nop();
        @(posedge clk);
        #1;
        check("mid_rst_req",   dbus_if.dbus_req,  0);
        check("mid_rst_addr",  dbus_if.dbus_addr, 0);
        check("mid_rst_stall", mem_stall,         0);
        check("mid_rst_wb",    {wb_reg_write, wb_mem_to_reg, wb_register_rd}, 0);
        @(negedge clk);
        rst = 1'b0;
        dbus_if.dbus_rvalid = 1'b1;
        dbus_if.dbus_rdata  = 32'hBAD0BAD0;
        @(negedge clk);
        dbus_if.dbus_rvalid = 1'b0;
        dbus_if.dbus_rdata  = 32'h0;
        #1;
        check("stray_req",   dbus_if.dbus_req, 0);
        check("stray_stall", mem_stall,        0);
        check("stray_data",  wb_mem_rdata,     0);
        run_vec(tbl[3], "post_rst");

`ifdef FB_MEM_TIMEOUT_EN
        begin
            vec_t tv;
            tv = '{1'b1,1'b0,1'b1,1'b1, 32'h300, 32'h0, 5'd7, 99,0, 32'h0,
                   1'b0, 5,4, 1'b0,1'b1, 32'hDEADBEEF, 1};
            run_vec(tv, "timeout");
            run_vec(tbl[4], "post_to");
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual simulation still running required finish");
        $fatal(1, "bench time limit reached");
    end

endmodule
